adder_nbit_ahead_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder: DATA_W-bit operands plus carry-in, split into 4-bit lookahead groups, one or more groups resolved per pipeline stage. It is the wide-datapath successor of the 4-bit lookahead adder. It sits between producers and consumers that use valid/ready streaming and supports full-throughput operation with backpressure.

---
 rtl/adder_nbit_ahead_pipe.sv | 168 ++++++++++++++++
 tb/tb_adder_nbit_ahead_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_nbit_ahead_pipe.sv
// Pipelined carry-lookahead adder with elastic valid/ready stages.
// Define ADDER_NBIT_OVF_EN to add the o_ovf signed-overflow output.

module adder_nbit_ahead_pipe #(
    parameter int DATA_W      = 16,
    parameter int GRP_PER_STG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_num_a,
    input  logic [DATA_W-1:0] i_num_b,
    input  logic              i_cry,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_res,
`ifdef ADDER_NBIT_OVF_EN
    output logic              o_cry,
    output logic              o_ovf
`else
    output logic              o_cry
`endif
);

    localparam int SW     = 4 * GRP_PER_STG;
    localparam int STAGES = DATA_W / SW;

    if (GRP_PER_STG < 1 || DATA_W < SW || DATA_W % SW != 0) begin : g_bad_cfg
        $error("DATA_W must be a non-zero multiple of 4*GRP_PER_STG");
    end

    // One stage slice: bit G/P, 4-bit group lookahead, group G/P second level.
    function automatic logic [SW:0] slice_add(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic          ci
    );
        logic [SW-1:0]          g, p, c;
        logic [GRP_PER_STG-1:0] gg, gp;
        logic [GRP_PER_STG:0]   gc;
        logic                   t;
        g = a & b;
        p = a ^ b;
        for (int j = 0; j < GRP_PER_STG; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = ci;
        for (int j = 1; j <= GRP_PER_STG; j++) begin
            gc[j] = 1'b0;
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int m = i + 1; m < j; m++) t = t & gp[m];
                gc[j] = gc[j] | t;
            end
            t = ci;
            for (int m = 0; m < j; m++) t = t & gp[m];
            gc[j] = gc[j] | t;
        end
        for (int j = 0; j < GRP_PER_STG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1]
                     | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2]
                     | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {gc[GRP_PER_STG], p ^ c};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO  = SW * k;
        localparam int REM = DATA_W - LO;

        logic [REM-1:0]   a_in, b_in;
        logic             c_in, v_in;
        logic             rdy, rdy_dn;
        logic [LO+SW-1:0] s_nxt;
        logic [SW:0]      r;
        logic             v_q, c_q;
        logic [LO+SW-1:0] s_q;

        if (k == 0) begin : g_src
            assign a_in  = i_num_a;
            assign b_in  = i_num_b;
            assign c_in  = i_cry;
            assign v_in  = i_valid;
            assign s_nxt = r[SW-1:0];
        end else begin : g_src
            assign a_in  = stg[k-1].g_ops.a_q;
            assign b_in  = stg[k-1].g_ops.b_q;
            assign c_in  = stg[k-1].c_q;
            assign v_in  = stg[k-1].v_q;
            assign s_nxt = {r[SW-1:0], stg[k-1].s_q};
        end

        if (k == STAGES - 1) begin : g_dn
            assign rdy_dn = i_ready;
        end else begin : g_dn
            assign rdy_dn = stg[k+1].rdy;
        end

        assign r   = slice_add(a_in[SW-1:0], b_in[SW-1:0], c_in);
        assign rdy = ~v_q | rdy_dn;

        // Stage register: advance when empty or drained; data moves only with valid.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (rdy) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q <= r[SW];
                    s_q <= s_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [REM-SW-1:0] a_q, b_q;

            // Operand bits still waiting for their slice.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (rdy && v_in) begin
                    a_q <= a_in[REM-1:SW];
                    b_q <= b_in[REM-1:SW];
                end
            end
        end

`ifdef ADDER_NBIT_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            // Overflow: operands agree in sign, result sign differs.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    ovf_q <= 1'b0;
                end else if (rdy && v_in) begin
                    ovf_q <= (a_in[SW-1] == b_in[SW-1])
                          && (r[SW-1] != a_in[SW-1]);
                end
            end
        end
`endif
    end

    assign o_ready = stg[0].rdy;
    assign o_valid = stg[STAGES-1].v_q;
    assign o_res   = stg[STAGES-1].s_q;
    assign o_cry   = stg[STAGES-1].c_q;
`ifdef ADDER_NBIT_OVF_EN
    assign o_ovf   = stg[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_adder_nbit_ahead_pipe.sv
// Bench for adder_nbit_ahead_pipe: 16-bit/1-group and 32-bit/2-group
// instances checked against arithmetic models with FIFO scoreboards.

module tb_adder_nbit_ahead_pipe;

    localparam int S1 = 4;
    localparam int S2 = 4;

    logic        clk;
    logic        rst_n;

    logic        v1, rdy1, ci1, ov1, ir1, co1;
    logic [15:0] a1, b1, res1;
    logic        v2, rdy2, ci2, ov2, ir2, co2;
    logic [31:0] a2, b2, res2;
`ifdef ADDER_NBIT_OVF_EN
    logic        of1, of2;
`endif

    typedef struct {
        logic [31:0] res;
        logic        cry;
        logic        ovf;
        int          t;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          lat1    = 1'b1;
    bit          hv1     = 1'b0;
    logic [17:0] hval1;
    bit          stall_seen;

    logic [15:0] va[8] = '{16'h1234, 16'h7FFF, 16'h8000, 16'hFFFF,
                           16'h0000, 16'h0000, 16'hAAAA, 16'h7FFF};
    logic [15:0] vb[8] = '{16'h4321, 16'h0001, 16'h8000, 16'hFFFF,
                           16'h0000, 16'h0000, 16'h5555, 16'h7FFF};
    logic        vc[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    adder_nbit_ahead_pipe #(.DATA_W(16), .GRP_PER_STG(1)) u_dut16 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (v1),
        .o_ready (rdy1),
        .i_num_a (a1),
        .i_num_b (b1),
        .i_cry   (ci1),
        .o_valid (ov1),
        .i_ready (ir1),
        .o_res   (res1),
`ifdef ADDER_NBIT_OVF_EN
        .o_cry   (co1),
        .o_ovf   (of1)
`else
        .o_cry   (co1)
`endif
    );

    adder_nbit_ahead_pipe #(.DATA_W(32), .GRP_PER_STG(2)) u_dut32 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (v2),
        .o_ready (rdy2),
        .i_num_a (a2),
        .i_num_b (b2),
        .i_cry   (ci2),
        .o_valid (ov2),
        .i_ready (ir2),
        .o_res   (res2),
`ifdef ADDER_NBIT_OVF_EN
        .o_cry   (co2),
        .o_ovf   (of2)
`else
        .o_cry   (co2)
`endif
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk16(input logic [15:0] a, input logic [15:0] b,
                                  input logic c);
        exp_t        e;
        logic [16:0] s;
        int          sa;
        s     = {1'b0, a} + {1'b0, b} + 17'(c);
        sa    = int'($signed(a)) + int'($signed(b)) + int'(c);
        e.res = 32'(s[15:0]);
        e.cry = s[16];
        e.ovf = (sa > 32767) || (sa < -32768);
        e.t   = cyc;
        return e;
    endfunction

    function automatic exp_t mk32(input logic [31:0] a, input logic [31:0] b,
                                  input logic c);
        exp_t        e;
        logic [32:0] s;
        longint      sa;
        s     = {1'b0, a} + {1'b0, b} + 33'(c);
        sa    = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        e.res = s[31:0];
        e.cry = s[32];
        e.ovf = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
        e.t   = cyc;
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        chk("ready16", 64'(rdy1), 64'(!(q1.size() == S1 && !ir1)));
        chk("ready32", 64'(rdy2), 64'(!(q2.size() == S2 && !ir2)));
        if (hv1) chk("hold16", 64'({ov1, co1, res1}), 64'(hval1));
        hv1   = ov1 && !ir1;
        hval1 = {ov1, co1, res1};
        if (ov1 && ir1) begin
            chk("expect16", 64'(q1.size() != 0), 64'(1));
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("res16", 64'(res1), 64'(e.res[15:0]));
                chk("cry16", 64'(co1), 64'(e.cry));
`ifdef ADDER_NBIT_OVF_EN
                chk("ovf16", 64'(of1), 64'(e.ovf));
`endif
                if (lat1) chk("lat16", 64'(cyc - e.t), 64'(S1));
            end
        end
        if (ov2 && ir2) begin
            chk("expect32", 64'(q2.size() != 0), 64'(1));
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("res32", 64'(res2), 64'(e.res));
                chk("cry32", 64'(co2), 64'(e.cry));
`ifdef ADDER_NBIT_OVF_EN
                chk("ovf32", 64'(of2), 64'(e.ovf));
`endif
                chk("lat32", 64'(cyc - e.t), 64'(S2));
            end
        end
        if (v1 && rdy1) q1.push_back(mk16(a1, b1, ci1));
        if (v2 && rdy2) q2.push_back(mk32(a2, b2, ci2));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst_n = 1'b1;
        v1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; ir1 = 1'b1;
        v2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; ir2 = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid16", 64'(ov1), 64'(0));
        chk("rst_res16", 64'(res1), 64'(0));
        chk("rst_cry16", 64'(co1), 64'(0));
        chk("rst_valid32", 64'(ov2), 64'(0));
`ifdef ADDER_NBIT_OVF_EN
        chk("rst_ovf16", 64'(of1), 64'(0));
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_ready16", 64'(rdy1), 64'(1));

        // Single add with full carry ripple.
        v1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0001; ci1 = 1'b0;
        tick();
        v1 = 1'b0;
        repeat (6) tick();

        // Back-to-back directed stream.
        for (int i = 0; i < 8; i++) begin
            v1 = 1'b1; a1 = va[i]; b1 = vb[i]; ci1 = vc[i];
            tick();
        end
        v1 = 1'b0;
        repeat (6) tick();

        // Continuous stream with a 6-cycle downstream stall.
        lat1 = 1'b0;
        stall_seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            v1  = 1'b1;
            a1  = 16'($urandom);
            b1  = 16'($urandom);
            ci1 = 1'($urandom);
            ir1 = !(i >= 6 && i < 12);
            tick();
            if (!rdy1) stall_seen = 1'b1;
        end
        v1 = 1'b0; ir1 = 1'b1;
        repeat (8) tick();
        chk("stall_seen", 64'(stall_seen), 64'(1));
        chk("drain_bp", 64'(q1.size()), 64'(0));

        // Random valid/ready traffic.
        for (int i = 0; i < 400; i++) begin
            v1  = $urandom_range(0, 3) != 0;
            ir1 = $urandom_range(0, 3) != 0;
            a1  = 16'($urandom);
            b1  = 16'($urandom);
            ci1 = 1'($urandom);
            tick();
        end
        v1 = 1'b0; ir1 = 1'b1;
        repeat (8) tick();
        chk("drain_rand", 64'(q1.size()), 64'(0));

        // Reset with three operations in flight, first one at the output.
        lat1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v1 = 1'b1;
            a1 = 16'($urandom); b1 = 16'($urandom); ci1 = 1'($urandom);
            tick();
        end
        v1 = 1'b0;
        tick();
        chk("pre_rst_valid", 64'(ov1), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(ov1), 64'(0));
        chk("mid_rst_res", 64'(res1), 64'(0));
        chk("mid_rst_cry", 64'(co1), 64'(0));
`ifdef ADDER_NBIT_OVF_EN
        chk("mid_rst_ovf", 64'(of1), 64'(0));
`endif
        q1.delete();
        hv1 = 1'b0;
        #1 rst_n = 1'b1;
        repeat (8) tick();
        chk("no_stale", 64'(ov1), 64'(0));

        // 32-bit, two groups per stage.
        v2 = 1'b1; a2 = 32'hFFFF_FFFF; b2 = 32'h0; ci2 = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            a2  = $urandom;
            b2  = $urandom;
            ci2 = 1'($urandom);
            tick();
        end
        v2 = 1'b0;
        repeat (8) tick();
        chk("drain32", 64'(q2.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
